rvfi_retire_packer: RTL

//  Transmit side of the RVFI trace interface: accepts one retired-instruction record per cycle

---
 rtl/rvfi_retire_packer.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/rvfi_retire_packer.sv
`default_nettype none
// ============================================================================
// Module   : rvfi_retire_packer
// Purpose  : Buffers retired-instruction records and packs them onto NRET
//            RVFI channels, assigning a monotonic 8-bit rvfi_order.
// Revision : 1.0 - initial release
// ============================================================================
module rvfi_retire_packer #(
    parameter int NRET  = 2,
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          resetn,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [31:0]                   in_insn,
    input  logic [4:0]                    in_rs1_addr,
    input  logic [4:0]                    in_rs2_addr,
    input  logic [4:0]                    in_rd_addr,
    input  logic [XLEN-1:0]               in_pre_pc,
    input  logic [XLEN-1:0]               in_post_pc,
    input  logic [XLEN-1:0]               in_rs1_rdata,
    input  logic [XLEN-1:0]               in_rs2_rdata,
    input  logic [XLEN-1:0]               in_post_rd,
    input  logic                          in_trap,
    input  logic [XLEN-1:0]               in_mem_addr,
    input  logic [XLEN-1:0]               in_mem_rdata,
    input  logic [XLEN-1:0]               in_mem_wdata,
    input  logic [XLEN/8-1:0]             in_mem_rmask,
    input  logic [XLEN/8-1:0]             in_mem_wmask,
    input  logic                          drain_en,
    output logic [$clog2(DEPTH+1)-1:0]    fifo_level,
    output logic [NRET-1:0]               rvfi_valid,
    output logic [NRET*8-1:0]             rvfi_order,
    output logic [NRET*32-1:0]            rvfi_insn,
    output logic [NRET*5-1:0]             rvfi_rs1_addr,
    output logic [NRET*5-1:0]             rvfi_rs2_addr,
    output logic [NRET*5-1:0]             rvfi_rd_addr,
    output logic [NRET*XLEN-1:0]          rvfi_pre_pc,
    output logic [NRET*XLEN-1:0]          rvfi_post_pc,
    output logic [NRET*XLEN-1:0]          rvfi_rs1_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_rs2_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_post_rd,
    output logic [NRET-1:0]               rvfi_trap,
    output logic [NRET*XLEN-1:0]          rvfi_mem_addr,
    output logic [NRET*XLEN-1:0]          rvfi_mem_rdata,
    output logic [NRET*XLEN-1:0]          rvfi_mem_wdata,
    output logic [NRET*XLEN/8-1:0]        rvfi_mem_rmask,
    output logic [NRET*XLEN/8-1:0]        rvfi_mem_wmask
);

    localparam int MW = XLEN / 8;
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int LW = $clog2(DEPTH + 1);

    localparam logic [PW:0]   c_depth_ext = (PW + 1)'(DEPTH);
    localparam logic [LW-1:0] c_depth_lvl = LW'(DEPTH);
    localparam logic [LW-1:0] c_nret_lvl  = LW'(NRET);

    typedef struct packed {
        logic [31:0]     insn;
        logic            trap;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [XLEN-1:0] pre_pc;
        logic [XLEN-1:0] post_pc;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [XLEN-1:0] post_rd;
        logic [XLEN-1:0] mem_addr;
        logic [XLEN-1:0] mem_rdata;
        logic [XLEN-1:0] mem_wdata;
        logic [MW-1:0]   mem_rmask;
        logic [MW-1:0]   mem_wmask;
    } rec_t;

    rec_t            r_mem [DEPTH];
    logic [PW-1:0]   r_head;
    logic [PW-1:0]   r_tail;
    logic [LW-1:0]   r_level;
    logic [7:0]      r_ord;

    rec_t            r_out   [NRET];
    logic [7:0]      r_order [NRET];
    logic [NRET-1:0] r_valid;

    rec_t            w_rec;
    logic            w_push;
    logic [LW-1:0]   w_npop;
    logic [NRET-1:0] w_take;
    logic [PW-1:0]   w_rd_idx [NRET];

    // Pointers never exceed 2*DEPTH-1 before wrapping, so one subtraction suffices
    // and DEPTH need not be a power of two.
    function automatic logic [PW-1:0] f_wrap(input logic [PW:0] x);
        logic [PW:0] y;
        y = (x >= c_depth_ext) ? (x - c_depth_ext) : x;
        return y[PW-1:0];
    endfunction

    // Credit is taken from the registered level only; a pop in the same cycle
    // does not free a slot for the incoming record.
    assign in_ready   = resetn && (r_level < c_depth_lvl);
    assign w_push     = in_valid && in_ready;
    assign fifo_level = r_level;

    always_comb begin
        w_rec           = '0;
        w_rec.insn      = in_insn;
        w_rec.trap      = in_trap;
        w_rec.rs1_addr  = in_rs1_addr;
        w_rec.rs2_addr  = in_rs2_addr;
        w_rec.rd_addr   = in_rd_addr;
        w_rec.pre_pc    = in_pre_pc;
        w_rec.post_pc   = in_post_pc;
        w_rec.rs1_rdata = in_rs1_rdata;
        w_rec.rs2_rdata = in_rs2_rdata;
        w_rec.post_rd   = (in_rd_addr == 5'd0) ? '0 : in_post_rd;
        w_rec.mem_addr  = in_mem_addr;
        w_rec.mem_rdata = in_mem_rdata;
        w_rec.mem_wdata = in_mem_wdata;
        w_rec.mem_rmask = in_mem_rmask;
        w_rec.mem_wmask = in_mem_wmask;
    end

    always_comb begin
        w_npop = '0;
        if (drain_en) begin
            w_npop = (r_level < c_nret_lvl) ? r_level : c_nret_lvl;
        end
        for (int k = 0; k < NRET; k++) begin
            w_take[k]   = (LW'(k) < w_npop);
            w_rd_idx[k] = f_wrap({1'b0, r_head} + (PW + 1)'(k));
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_tail] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_level <= '0;
            r_ord   <= '0;
        end else begin
            r_head  <= f_wrap({1'b0, r_head} + (PW + 1)'(w_npop));
            r_tail  <= f_wrap({1'b0, r_tail} + (PW + 1)'(w_push));
            r_level <= r_level + LW'(w_push) - w_npop;
            r_ord   <= r_ord + 8'(w_npop);
        end
    end

    // Unused channels are zeroed every cycle so stale data never lingers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid <= '0;
            for (int k = 0; k < NRET; k++) begin
                r_out[k]   <= '0;
                r_order[k] <= '0;
            end
        end else begin
            r_valid <= w_take;
            for (int k = 0; k < NRET; k++) begin
                r_out[k]   <= w_take[k] ? r_mem[w_rd_idx[k]] : '0;
                r_order[k] <= w_take[k] ? (r_ord + 8'(k)) : 8'd0;
            end
        end
    end

    for (genvar k = 0; k < NRET; k++) begin : g_chan
        assign rvfi_valid[k]                   = r_valid[k];
        assign rvfi_order[k*8 +: 8]            = r_order[k];
        assign rvfi_insn[k*32 +: 32]           = r_out[k].insn;
        assign rvfi_trap[k]                    = r_out[k].trap;
        assign rvfi_rs1_addr[k*5 +: 5]         = r_out[k].rs1_addr;
        assign rvfi_rs2_addr[k*5 +: 5]         = r_out[k].rs2_addr;
        assign rvfi_rd_addr[k*5 +: 5]          = r_out[k].rd_addr;
        assign rvfi_pre_pc[k*XLEN +: XLEN]     = r_out[k].pre_pc;
        assign rvfi_post_pc[k*XLEN +: XLEN]    = r_out[k].post_pc;
        assign rvfi_rs1_rdata[k*XLEN +: XLEN]  = r_out[k].rs1_rdata;
        assign rvfi_rs2_rdata[k*XLEN +: XLEN]  = r_out[k].rs2_rdata;
        assign rvfi_post_rd[k*XLEN +: XLEN]    = r_out[k].post_rd;
        assign rvfi_mem_addr[k*XLEN +: XLEN]   = r_out[k].mem_addr;
        assign rvfi_mem_rdata[k*XLEN +: XLEN]  = r_out[k].mem_rdata;
        assign rvfi_mem_wdata[k*XLEN +: XLEN]  = r_out[k].mem_wdata;
        assign rvfi_mem_rmask[k*MW +: MW]      = r_out[k].mem_rmask;
        assign rvfi_mem_wmask[k*MW +: MW]      = r_out[k].mem_wmask;
    end

endmodule
`default_nettype wire
